// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter plus instruction-memory fetch engine that
// hands each fetched word to the ControlUnit over a valid/ack handshake and
// computes the next PC from pc_sel, K and reg_target when the word is acked.
// Optional feature macro: FETCH_FAULT_EN. When it is defined, a misaligned
// next PC parks the block in a FAULT state. When it is undefined, the next PC
// is force-aligned and fault is tied low.
module instruction_fetch #(
  parameter int unsigned          ADDR_BITS  = 64,
  parameter int unsigned          INSTR_BITS = 32,
  parameter logic [ADDR_BITS-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_BITS-1:0]  mem_addr,
  input  logic                  mem_ready,
  input  logic [INSTR_BITS-1:0] mem_rdata,
  output logic [INSTR_BITS-1:0] instruction,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  input  logic [1:0]            pc_sel,
  input  logic [ADDR_BITS-1:0]  K,
  input  logic [ADDR_BITS-1:0]  reg_target,
  output logic [ADDR_BITS-1:0]  pc,
  output logic                  fault
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] ISSUED = 2'd2;
`ifdef FETCH_FAULT_EN
  localparam logic [1:0] FAULT  = 2'd3;
`endif

  logic [1:0]            state_q,       state_d;
  logic [ADDR_BITS-1:0]  pc_q,          pc_d;
  logic                  mem_req_q,     mem_req_d;
  logic [INSTR_BITS-1:0] instruction_q, instruction_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [ADDR_BITS-1:0]  next_pc_c;
`ifdef FETCH_FAULT_EN
  logic                  fault_q,       fault_d;
`endif

  // Next-PC candidate; pc_sel 11 is reserved and behaves like sequential fetch.
  always_comb begin
    next_pc_c = pc_q + ADDR_BITS'(4);
    case (pc_sel)
      2'b01:   next_pc_c = pc_q + (K << 2);
      2'b10:   next_pc_c = reg_target;
      default: next_pc_c = pc_q + ADDR_BITS'(4);
    endcase
  end

  // Fetch/issue sequencing and next-state computation for all registered outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_req_d     = mem_req_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_FAULT_EN
    fault_d       = fault_q;
`endif
    case (state_q)
      IDLE: begin
        state_d   = FETCH;
        mem_req_d = 1'b1;
      end
      FETCH: begin
        if (mem_ready) begin
          instruction_d = mem_rdata;
          mem_req_d     = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = ISSUED;
        end
      end
      ISSUED: begin
        if (instr_ack && instr_valid_q) begin
          instr_valid_d = 1'b0;
`ifdef FETCH_FAULT_EN
          if (next_pc_c[1:0] != 2'b00) begin
            // Misaligned target: keep pc, stop fetching until reset.
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d      = next_pc_c;
            mem_req_d = 1'b1;
            state_d   = FETCH;
          end
`else
          pc_d      = next_pc_c & ~ADDR_BITS'(3);
          mem_req_d = 1'b1;
          state_d   = FETCH;
`endif
        end
      end
`ifdef FETCH_FAULT_EN
      FAULT: begin
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
      end
`endif
      default: begin
        state_d       = IDLE;
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      mem_req_q     <= 1'b0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_FAULT_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_req_q     <= mem_req_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_FAULT_EN
      fault_q       <= fault_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
`ifdef FETCH_FAULT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed steps plus a randomized phase,
// all checked against a next-PC reference model written with plain arithmetic.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ack;
  logic [1:0]  pc_sel;
  logic [63:0] K;
  logic [63:0] reg_target;
  logic [63:0] pc;
  logic        fault;

  int          errors;
  int          checks;
  logic [63:0] exp_pc;

  instruction_fetch dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .pc_sel      (pc_sel),
    .K           (K),
    .reg_target  (reg_target),
    .pc          (pc),
    .fault       (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference next PC: sequential, word-relative branch, or absolute target.
  function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [1:0] s,
                                           input longint k, input logic [63:0] t);
    logic [63:0] n;
    if (s == 2'b01)      n = p + 64'(k * 4);
    else if (s == 2'b10) n = t;
    else                 n = p + 64'd4;
`ifndef FETCH_FAULT_EN
    n[1:0] = 2'b00;
`endif
    return n;
  endfunction

  // Reset with mem_ready/ack active, release one full cycle before the first fetch.
  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    instr_ack = 1'b1;
    @(negedge clock);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_pc", pc, 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("idle_mem_req", 64'(mem_req), 64'd0);
    check("idle_valid", 64'(instr_valid), 64'd0);
    @(negedge clock);
    mem_ready = 1'b0;
    instr_ack = 1'b0;
    exp_pc    = 64'd0;
    check("first_req", 64'(mem_req), 64'd1);
    check("first_addr", mem_addr, 64'd0);
    check("first_valid", 64'(instr_valid), 64'd0);
  endtask

  // One full fetch/issue/ack round trip with rwait memory waits and await ack waits.
  task automatic fetch_issue(input logic [31:0] rdata, input int rwait, input int await_n,
                             input logic [1:0] sel, input longint k, input logic [63:0] tgt);
    mem_ready = 1'b0;
    instr_ack = 1'b0;
    check("fetch_req", 64'(mem_req), 64'd1);
    check("fetch_addr", mem_addr, exp_pc);
    check("fetch_valid", 64'(instr_valid), 64'd0);
    for (int i = 0; i < rwait; i++) begin
      instr_ack = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clock);
      check("wait_req", 64'(mem_req), 64'd1);
      check("wait_addr", mem_addr, exp_pc);
      check("wait_valid", 64'(instr_valid), 64'd0);
    end
    instr_ack = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = rdata;
    @(negedge clock);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    check("issue_valid", 64'(instr_valid), 64'd1);
    check("issue_instr", 64'(instruction), 64'(rdata));
    check("issue_req", 64'(mem_req), 64'd0);
    check("issue_pc", pc, exp_pc);
    for (int i = 0; i < await_n; i++) begin
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      pc_sel    = 2'($urandom);
      @(negedge clock);
      check("hold_valid", 64'(instr_valid), 64'd1);
      check("hold_instr", 64'(instruction), 64'(rdata));
      check("hold_req", 64'(mem_req), 64'd0);
    end
    mem_ready  = 1'b0;
    instr_ack  = 1'b1;
    pc_sel     = sel;
    K          = k;
    reg_target = tgt;
    @(negedge clock);
    instr_ack  = 1'b0;
    pc_sel     = 2'($urandom);
    K          = {$urandom, $urandom};
    reg_target = {$urandom, $urandom};
    exp_pc     = ref_next(exp_pc, sel, k, tgt);
    check("ack_valid", 64'(instr_valid), 64'd0);
    check("ack_req", 64'(mem_req), 64'd1);
    check("ack_next_addr", mem_addr, exp_pc);
    check("ack_fault", 64'(fault), 64'd0);
  endtask

  initial begin
    logic [63:0] tgt;
    longint      kv;
    errors     = 0;
    checks     = 0;
    exp_pc     = 64'd0;
    reset      = 1'b1;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;
    instr_ack  = 1'b0;
    pc_sel     = 2'b00;
    K          = 64'd0;
    reg_target = 64'd0;

    // Sequential fetch 0,4,8,C with immediate ready/ack
    do_reset();
    for (int i = 0; i < 4; i++) fetch_issue($urandom, 0, 0, 2'b00, 0, 64'd0);
    check("seq_end_addr", mem_addr, 64'h10);

    // Five memory wait states
    fetch_issue(32'hDEAD_BEEF, 5, 0, 2'b00, 0, 64'd0);

    // Relative branches from 0x40
    fetch_issue($urandom, 0, 0, 2'b10, 0, 64'h40);
    fetch_issue($urandom, 0, 0, 2'b01, -2, 64'd0);
    check("branch_back", mem_addr, 64'h38);
    fetch_issue($urandom, 0, 0, 2'b10, 0, 64'h40);
    fetch_issue($urandom, 0, 0, 2'b01, 3, 64'd0);
    check("branch_fwd", mem_addr, 64'h4C);

    // Wrap-around, absolute jump with ack stall, reserved select
    fetch_issue($urandom, 1, 0, 2'b10, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_issue($urandom, 0, 0, 2'b00, 0, 64'd0);
    check("wrap_zero", mem_addr, 64'd0);
    fetch_issue(32'h1234_5678, 0, 4, 2'b10, 0, 64'h1000);
    check("jump_1000", mem_addr, 64'h1000);
    fetch_issue($urandom, 0, 0, 2'b11, 0, 64'd0);
    check("reserved_sel", mem_addr, 64'h1004);

    // Randomized traffic, including large K whose top bits shift out
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 4) kv = longint'({$urandom, $urandom});
      else            kv = longint'($urandom_range(200)) - 100;
      tgt = {$urandom, $urandom};
`ifdef FETCH_FAULT_EN
      tgt[1:0] = 2'b00;
`endif
      fetch_issue($urandom, int'($urandom_range(3)), int'($urandom_range(3)),
                  2'($urandom), kv, tgt);
    end

    // Misaligned register target
    fetch_issue($urandom, 0, 0, 2'b10, 0, 64'h1000);
`ifdef FETCH_FAULT_EN
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    @(negedge clock);
    mem_ready  = 1'b0;
    instr_ack  = 1'b1;
    pc_sel     = 2'b10;
    reg_target = 64'h1002;
    @(negedge clock);
    instr_ack = 1'b0;
    check("fault_set", 64'(fault), 64'd1);
    check("fault_req", 64'(mem_req), 64'd0);
    check("fault_valid", 64'(instr_valid), 64'd0);
    check("fault_pc", pc, 64'h1000);
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'($urandom);
      instr_ack = 1'($urandom);
      @(negedge clock);
      check("fault_stuck_req", 64'(mem_req), 64'd0);
      check("fault_stuck", 64'(fault), 64'd1);
    end
    do_reset();
    fetch_issue($urandom, 0, 0, 2'b10, 0, 64'h1000);
`else
    fetch_issue($urandom, 0, 0, 2'b10, 0, 64'h1002);
    check("misalign_forced", mem_addr, 64'h1000);
    check("misalign_nofault", 64'(fault), 64'd0);
`endif

    // Reset during FETCH with mem_ready asserted on the same edge
    check("pre_reset_pc", pc, 64'h1000);
    do_reset();
    fetch_issue($urandom, 0, 0, 2'b00, 0, 64'd0);
    check("post_reset_seq", mem_addr, 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
